clint_mh: RTL and testbench
===========================

# clint_mh

Multi-hart, parametrised core-local interruptor that supersedes the single-hart timer/software-interrupt block. It provides one shared 64-bit `mtime` counter advanced by a programmable clock prescaler, plus a per-hart `mtimecmp` and `msip` register, over the same single-cycle word-addressed register port used by the core's memory-mapped peripherals. Per-hart timer and software interrupt lines feed each core's CSR/trap logic.

## Interface
- `N_HARTS`, default 1: number of harts (1–16), each with its own `mtimecmp`/`msip` and interrupt outputs.
- `TICK_DIV`, default 100_000: `clk` cycles per `mtime` increment (≥1); 1 means increment every cycle.
- `ADDR_W`, default 14: width of the word address.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: access strobe; a read occurs when `en && !we`, a write when `en && we`.
- `we` in 1: write enable, valid only with `en`.
- `addr` in ADDR_W: word (32-bit) address.
- `data_in` in 32: write data.
- `data_out` out 32: registered read data.
- `tmr_irq` out N_HARTS: per-hart machine timer interrupt, registered.
- `sft_irq` out N_HARTS: per-hart machine software interrupt.

## Operation
- Word map:
  - `0x0000+h`: `msip[h]`; only bit 0 is stored, bits 31:1 read as 0.
  - `0x1000+2h` / `0x1001+2h`: `mtimecmp[h]` low / high.
  - `0x2FFE` / `0x2FFF`: `mtime` low / high.
  - Any other address, or a hart index ≥ N_HARTS: reads return 0, writes are ignored.
- Prescaler: a counter of width `$clog2(TICK_DIV)` (min 1) counts 0..TICK_DIV-1 and wraps.
  - `tick` is high in the cycle the counter equals TICK_DIV-1.
  - With TICK_DIV=1, `tick` is high every cycle.
  - Mtime writes do not reset the prescaler.
- `mtime` advances by +1 on `tick`. It is a full 64-bit counter: the high word increments only when the low word is 0xFFFF_FFFF and `tick` is high. `0xFFFF_FFFF_FFFF_FFFF` wraps to 0.
- Writing `mtime` low in a cycle:
  - low takes `data_in` (the write wins over the tick);
  - high receives no carry that cycle.
- Writing `mtime` high in a cycle:
  - high takes `data_in`;
  - low still increments on `tick`, and any carry out of low is dropped.
- `tmr_irq[h]` is registered `mtime >= mtimecmp[h]`, an unsigned 64-bit compare of current register values.
- `sft_irq[h] = msip[h]`, taken directly from the register with no added logic.
- Reads return live register values, except for the snapshot behaviour described under Configuration.

## Timing
- Reset values:
  - `mtime` = 0, prescaler = 0;
  - every `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF, so no timer interrupt fires after reset;
  - `msip` = 0, `data_out` = 0, `tmr_irq` = 0, `sft_irq` = 0;
  - snapshot register = 0.
- A reset asserted mid-count clears everything on the next edge. Reset has priority over writes and ticks.
- Write: takes effect at the edge where `en && we` is sampled.
- Read: `data_out` is valid one cycle after `en && !we` and holds its value until the next read.
  - A read returns the value held before that edge; a same-cycle tick is not visible.
- `tmr_irq`: 1-cycle latency from the `mtime` or `mtimecmp` update that changes the compare result.
- `sft_irq`: visible in the cycle after the `msip` write.
- Back-to-back accesses are allowed every cycle. There is no stall and no busy state.

## Configuration
- Macro: `CLINT_MTIME_SNAPSHOT_EN`.
- Defined:
  - a read of `mtime` low also latches the current `mtime` high into a 32-bit shadow;
  - a subsequent read of `mtime` high returns the shadow, so a low-then-high read pair is coherent across a carry;
  - writes to `mtime` high update the live register only.
- Undefined: no shadow register exists, and `mtime` high reads return the live value.

## Test plan
- Reset, N_HARTS=2 → all `mtimecmp` read 0xFFFF_FFFF_FFFF_FFFF, `mtime`=0, `tmr_irq`=2'b00, `sft_irq`=2'b00.
- Prescaler, TICK_DIV=4, run 40 cycles after reset → `mtime` low reads 10; TICK_DIV=1, 7 cycles → `mtime` low reads 7.
- Carry, TICK_DIV=1, write `mtime` high=0, low=0xFFFF_FFFE, wait 2 cycles → `mtime` = 0x1_0000_0000. With `CLINT_MTIME_SNAPSHOT_EN`, reading low at 0xFFFF_FFFF and then reading high → high returns 0.
- Timer IRQ, N_HARTS=2, write `mtimecmp[1]`=0x20 and `mtime`=0x1E, TICK_DIV=1 → `tmr_irq[1]` rises 1 cycle after `mtime` reaches 0x20 and `tmr_irq[0]` stays 0. Then write `mtimecmp[1]` high=1 → `tmr_irq[1]` falls 1 cycle later.
- Software IRQ, write 0xFFFF_FFFF to `msip[1]` → `sft_irq`=2'b10 and the readback is 0x1. Write to `msip[5]` with N_HARTS=2 → ignored, and its readback is 0.
- Collision, TICK_DIV=1, write `mtime` low=0x100 in a tick cycle → next read returns 0x100 and the read after that returns 0x101 (write wins over the tick, no lost or double increment).

Source files
------------

// File: rtl/clint_mh_if.sv
// Register access port for clint_mh: single-cycle word-addressed bus.
//   en       access strobe (read when !we, write when we)
//   we       write enable, qualified by en
//   addr     word address
//   data_in  write data
//   data_out registered read data, valid the cycle after a read
interface clint_mh_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_in;
    logic [31:0]       data_out;

    modport master (
        output en,
        output we,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  en,
        input  we,
        input  addr,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared prescaled 64-bit mtime, per-hart
// mtimecmp/msip, per-hart timer and software interrupt lines.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        clint_mh_if.slave register port (en/we/addr/data_in/data_out)
//   tmr_irq    per-hart timer interrupt, registered mtime >= mtimecmp[h]
//   sft_irq    per-hart software interrupt, straight from msip[h]
// Optional feature: CLINT_MTIME_SNAPSHOT_EN adds a shadow of mtime high that is
// latched on every mtime low read and returned by mtime high reads.
module clint_mh #(
    parameter int unsigned N_HARTS  = 1,
    parameter int unsigned TICK_DIV = 100_000,
    parameter int unsigned ADDR_W   = 14
) (
    input  logic               clk,
    input  logic               rst,
    clint_mh_if.slave          bus,
    output logic [N_HARTS-1:0] tmr_irq,
    output logic [N_HARTS-1:0] sft_irq
);

    localparam int unsigned PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [31:0] A_CMP  = 32'h0000_1000;
    localparam logic [31:0] A_MTL  = 32'h0000_2FFE;
    localparam logic [31:0] A_MTH  = 32'h0000_2FFF;

    logic [PW-1:0]      presc;
    logic               tick;
    logic [31:0]        mtime_lo;
    logic [31:0]        mtime_hi;
    logic [63:0]        mtimecmp [N_HARTS];
    logic [N_HARTS-1:0] msip;
    logic [31:0]        a;
    logic               wr;
    logic               rd;
    logic [N_HARTS-1:0] msip_sel;
    logic [N_HARTS-1:0] cmp_lo_sel;
    logic [N_HARTS-1:0] cmp_hi_sel;
    logic               mtl_wr;
    logic               mth_wr;
    logic               carry;
    logic [31:0]        hi_rd_val;
    logic [31:0]        rdata;

`ifdef CLINT_MTIME_SNAPSHOT_EN
    logic [31:0]        mtime_hi_shadow;
`endif

    assign a      = 32'(bus.addr);
    assign wr     = bus.en & bus.we;
    assign rd     = bus.en & ~bus.we;
    assign tick   = (presc == PMAX);
    assign mtl_wr = wr && (a == A_MTL);
    assign mth_wr = wr && (a == A_MTH);
    // A low write replaces the value that would have carried
    assign carry  = tick && (mtime_lo == 32'hFFFF_FFFF) && !mtl_wr;

    assign sft_irq = msip;

`ifdef CLINT_MTIME_SNAPSHOT_EN
    assign hi_rd_val = mtime_hi_shadow;
`else
    assign hi_rd_val = mtime_hi;
`endif

    // Per-hart address decode; indices >= N_HARTS never match
    always_comb begin
        msip_sel   = '0;
        cmp_lo_sel = '0;
        cmp_hi_sel = '0;
        for (int unsigned h = 0; h < N_HARTS; h++) begin
            msip_sel[h]   = (a == 32'(h));
            cmp_lo_sel[h] = (a == A_CMP + 32'(2 * h));
            cmp_hi_sel[h] = (a == A_CMP + 32'(2 * h + 1));
        end
    end

    // Read mux over live register values
    always_comb begin
        rdata = '0;
        if (a == A_MTL) rdata = mtime_lo;
        if (a == A_MTH) rdata = hi_rd_val;
        for (int unsigned h = 0; h < N_HARTS; h++) begin
            if (msip_sel[h])   rdata = {31'b0, msip[h]};
            if (cmp_lo_sel[h]) rdata = mtimecmp[h][31:0];
            if (cmp_hi_sel[h]) rdata = mtimecmp[h][63:32];
        end
    end

    // Prescaler; free-running, unaffected by mtime writes
    always_ff @(posedge clk) begin
        if (rst)       presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PW'(1);
    end

    // mtime: writes win over the tick, a high write drops the low carry
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_lo <= '0;
            mtime_hi <= '0;
        end else begin
            if (mtl_wr)    mtime_lo <= bus.data_in;
            else if (tick) mtime_lo <= mtime_lo + 32'd1;

            if (mth_wr)     mtime_hi <= bus.data_in;
            else if (carry) mtime_hi <= mtime_hi + 32'd1;
        end
    end

    // Per-hart registers and timer compare
    always_ff @(posedge clk) begin
        if (rst) begin
            msip    <= '0;
            tmr_irq <= '0;
            for (int unsigned h = 0; h < N_HARTS; h++) mtimecmp[h] <= '1;
        end else begin
            for (int unsigned h = 0; h < N_HARTS; h++) begin
                if (wr && msip_sel[h])   msip[h] <= bus.data_in[0];
                if (wr && cmp_lo_sel[h]) mtimecmp[h][31:0]  <= bus.data_in;
                if (wr && cmp_hi_sel[h]) mtimecmp[h][63:32] <= bus.data_in;
                tmr_irq[h] <= ({mtime_hi, mtime_lo} >= mtimecmp[h]);
            end
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge clk) begin
        if (rst)     bus.data_out <= '0;
        else if (rd) bus.data_out <= rdata;
    end

`ifdef CLINT_MTIME_SNAPSHOT_EN
    // Low read captures high so a low/high pair is carry-coherent
    always_ff @(posedge clk) begin
        if (rst)                   mtime_hi_shadow <= '0;
        else if (rd && a == A_MTL) mtime_hi_shadow <= mtime_hi;
    end
`endif

endmodule

// File: tb/tb_clint_mh.sv
// Bench for clint_mh: dut_a (2 harts, TICK_DIV=4) and dut_b (2 harts,
// TICK_DIV=1). Reads push expected data into a per-DUT queue; a monitor pops
// and compares data_out one cycle after each read is sampled.
module tb_clint_mh;

    typedef struct {
        logic [31:0] exp;
        logic [13:0] addr;
    } rd_t;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [1:0] tmr_a;
    logic [1:0] sft_a;
    logic [1:0] tmr_b;
    logic [1:0] sft_b;

    int checks = 0;
    int errors = 0;
    rd_t q_a[$];
    rd_t q_b[$];

    clint_mh_if #(.ADDR_W(14)) bus_a ();
    clint_mh_if #(.ADDR_W(14)) bus_b ();

    clint_mh #(.N_HARTS(2), .TICK_DIV(4), .ADDR_W(14)) dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .bus     (bus_a),
        .tmr_irq (tmr_a),
        .sft_irq (sft_a)
    );

    clint_mh #(.N_HARTS(2), .TICK_DIV(1), .ADDR_W(14)) dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .bus     (bus_b),
        .tmr_irq (tmr_b),
        .sft_irq (sft_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void pop_cmp(input int s, input logic [31:0] act);
        rd_t e;
        if ((s == 0 ? q_a.size() : q_b.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_%0d: unexpected read data %h, scoreboard empty", s, act);
        end else begin
            e = (s == 0) ? q_a.pop_front() : q_b.pop_front();
            cmp($sformatf("rd_%0d@%h", s, e.addr), act, e.exp);
        end
    endfunction

    // Monitors: a read sampled at this edge presents data_out shortly after
    always @(posedge clk) begin
        if (bus_a.en && !bus_a.we) begin
            #1;
            pop_cmp(0, bus_a.data_out);
        end
    end

    always @(posedge clk) begin
        if (bus_b.en && !bus_b.we) begin
            #1;
            pop_cmp(1, bus_b.data_out);
        end
    end

    task automatic drive(input int s, input logic e, input logic w,
                         input logic [13:0] ad, input logic [31:0] d);
        if (s == 0) begin
            bus_a.en = e; bus_a.we = w; bus_a.addr = ad; bus_a.data_in = d;
        end else begin
            bus_b.en = e; bus_b.we = w; bus_b.addr = ad; bus_b.data_in = d;
        end
    endtask

    task automatic wr(input int s, input logic [13:0] ad, input logic [31:0] d);
        drive(s, 1'b1, 1'b1, ad, d);
        @(negedge clk);
        drive(s, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rd(input int s, input logic [13:0] ad, input logic [31:0] exp);
        rd_t e;
        e.exp  = exp;
        e.addr = ad;
        if (s == 0) q_a.push_back(e);
        else        q_b.push_back(e);
        drive(s, 1'b1, 1'b0, ad, '0);
        @(negedge clk);
        drive(s, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] snap_hi_exp;
`ifdef CLINT_MTIME_SNAPSHOT_EN
        snap_hi_exp = 32'h0;
`else
        snap_hi_exp = 32'h1;
`endif
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        idle(3);
        cmp("rst_tmr_a", 32'(tmr_a), 32'h0);
        cmp("rst_sft_a", 32'(sft_a), 32'h0);
        cmp("rst_tmr_b", 32'(tmr_b), 32'h0);
        cmp("rst_sft_b", 32'(sft_b), 32'h0);

        // dut_a: reset values, then prescaler /4 over 40 edges
        rst_a = 1'b0;
        rd(0, 14'h2FFE, 32'h0);
        rd(0, 14'h1000, 32'hFFFF_FFFF);
        rd(0, 14'h1001, 32'hFFFF_FFFF);
        rd(0, 14'h1002, 32'hFFFF_FFFF);
        rd(0, 14'h1003, 32'hFFFF_FFFF);
        rd(0, 14'h0001, 32'h0);
        idle(34);
        rd(0, 14'h2FFE, 32'd10);

        // dut_a: mid-count reset, then an mtime write must not restart the prescaler
        rst_a = 1'b1;
        idle(1);
        rst_a = 1'b0;
        rd(0, 14'h2FFE, 32'h0);
        wr(0, 14'h2FFE, 32'd5);
        idle(2);
        rd(0, 14'h2FFE, 32'd6);
        rd(0, 14'h1004, 32'h0);
        rd(0, 14'h2FFD, 32'h0);

        // dut_b: TICK_DIV=1 counts every cycle
        rst_b = 1'b0;
        rd(1, 14'h2FFE, 32'h0);
        idle(6);
        rd(1, 14'h2FFE, 32'd7);

        // Carry from low into high
        wr(1, 14'h2FFF, 32'h0);
        wr(1, 14'h2FFE, 32'hFFFF_FFFE);
        idle(2);
        rd(1, 14'h2FFE, 32'h0);
        rd(1, 14'h2FFF, 32'h1);

        // Low read at 0xFFFF_FFFF followed by high read across the carry
        wr(1, 14'h2FFF, 32'h0);
        wr(1, 14'h2FFE, 32'hFFFF_FFFE);
        idle(1);
        rd(1, 14'h2FFE, 32'hFFFF_FFFF);
        rd(1, 14'h2FFF, snap_hi_exp);

        // High write in the carry cycle drops the carry
        wr(1, 14'h2FFE, 32'hFFFF_FFFF);
        wr(1, 14'h2FFF, 32'h5);
        rd(1, 14'h2FFE, 32'h0);
        rd(1, 14'h2FFF, 32'h5);

        // Timer interrupt on hart 1
        wr(1, 14'h2FFF, 32'h0);
        wr(1, 14'h2FFE, 32'h1E);
        wr(1, 14'h1003, 32'h0);
        wr(1, 14'h1002, 32'h20);
        cmp("tmr_b_pre", 32'(tmr_b), 32'h0);
        idle(1);
        cmp("tmr_b_rise", 32'(tmr_b), 32'h2);
        wr(1, 14'h1003, 32'h1);
        cmp("tmr_b_hold", 32'(tmr_b), 32'h2);
        idle(1);
        cmp("tmr_b_fall", 32'(tmr_b), 32'h0);

        // Software interrupt and out-of-range hart
        wr(1, 14'h0001, 32'hFFFF_FFFF);
        cmp("sft_b_set", 32'(sft_b), 32'h2);
        rd(1, 14'h0001, 32'h1);
        wr(1, 14'h0005, 32'h1);
        rd(1, 14'h0005, 32'h0);
        cmp("sft_b_ign", 32'(sft_b), 32'h2);
        rd(1, 14'h1004, 32'h0);
        rd(1, 14'h2FFD, 32'h0);
        rd(1, 14'h1002, 32'h20);
        rd(1, 14'h1003, 32'h1);
        rd(1, 14'h1000, 32'hFFFF_FFFF);

        // Low write in a tick cycle: no lost or double increment
        wr(1, 14'h2FFE, 32'h100);
        rd(1, 14'h2FFE, 32'h100);
        rd(1, 14'h2FFE, 32'h101);

        // Drain the scoreboard within a bounded wait
        for (int i = 0; i < 10; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            idle(1);
        end
        if (q_a.size() != 0 || q_b.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d/%0d reads never presented data, expected 0", q_a.size(), q_b.size());
        end
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
